// File: rtl/preg_freelist_if.sv
// Shared issue-width constant and the rename/commit-side interface of the
// physical-register free list. With FREELIST_STATS_EN defined the interface
// also carries the min_free low-water mark.
package core_pkg;
  localparam int ISSUE_WIDTH = 2;
endpackage

interface preg_freelist_if #(
  parameter int NUM_PREGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int ISSUE_W   = core_pkg::ISSUE_WIDTH
);
  localparam int TAG_W    = $clog2(NUM_PREGS);
  localparam int ARCH_W   = $clog2(ARCH_REGS);
  localparam int FL_DEPTH = NUM_PREGS - ARCH_REGS;
  localparam int CNT_W    = $clog2(FL_DEPTH) + 1;

  logic [ISSUE_W-1:0] alloc_req;
  logic               alloc_ok;
  logic [TAG_W-1:0]   alloc_tag [ISSUE_W];
  logic [ISSUE_W-1:0] commit_valid;
  logic [ARCH_W-1:0]  commit_arch_rd [ISSUE_W];
  logic [TAG_W-1:0]   commit_phys_rd [ISSUE_W];
  logic               flush_en;
  logic [CNT_W-1:0]   free_count;
  logic               free_empty;
  logic               overflow_err;
`ifdef FREELIST_STATS_EN
  logic [CNT_W-1:0]   min_free;

  modport master (
    output alloc_req, commit_valid, commit_arch_rd, commit_phys_rd, flush_en,
    input  alloc_ok, alloc_tag, free_count, free_empty, overflow_err, min_free
  );
  modport slave (
    input  alloc_req, commit_valid, commit_arch_rd, commit_phys_rd, flush_en,
    output alloc_ok, alloc_tag, free_count, free_empty, overflow_err, min_free
  );
`else
  modport master (
    output alloc_req, commit_valid, commit_arch_rd, commit_phys_rd, flush_en,
    input  alloc_ok, alloc_tag, free_count, free_empty, overflow_err
  );
  modport slave (
    input  alloc_req, commit_valid, commit_arch_rd, commit_phys_rd, flush_en,
    output alloc_ok, alloc_tag, free_count, free_empty, overflow_err
  );
`endif
endinterface

// File: rtl/preg_freelist.sv
// Physical-register free list plus retirement map table for the 2-wide
// rename/commit path. Rename takes tags from head, commit returns superseded
// tags at tail, and a flush rewinds head to commit_head.
// Optional macro FREELIST_STATS_EN adds the min_free low-water-mark output.
module preg_freelist #(
  parameter int NUM_PREGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int ISSUE_W   = core_pkg::ISSUE_WIDTH
) (
  input logic          clk,
  input logic          reset,
  preg_freelist_if.slave fl
);
  localparam int TAG_W    = $clog2(NUM_PREGS);
  localparam int FL_DEPTH = NUM_PREGS - ARCH_REGS;
  localparam int IDX_W    = $clog2(FL_DEPTH);
  localparam int CNT_W    = IDX_W + 1;

  typedef logic [TAG_W-1:0] preg_tag_t;
  typedef logic [CNT_W-1:0] ptr_t;

  localparam ptr_t           ONE     = ptr_t'(1);
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(FL_DEPTH);

  preg_tag_t fl_mem [FL_DEPTH];
  preg_tag_t rmt    [ARCH_REGS];

  ptr_t head, commit_head, tail;
  ptr_t head_nxt, commit_head_nxt, tail_nxt;
  ptr_t free_cnt, reqs, grant_cnt, rel_cnt, cmt_cnt, wr_ptr;
  logic grant;
  logic overflow_q, overflow_nxt;
  logic [CNT_W:0] fill;
  logic [ISSUE_W-1:0] rel_we, rmt_we;
  logic [IDX_W-1:0]   rel_idx [ISSUE_W];
  preg_tag_t          rel_tag [ISSUE_W];
  preg_tag_t          old_tag;

  // Wrap bit distinguishes a full list (tail-head = FL_DEPTH) from an empty one.
  assign free_cnt        = tail - head;
  assign fl.free_count   = free_cnt;
  assign fl.free_empty   = (free_cnt == '0);
  assign fl.overflow_err = overflow_q;
  assign fl.alloc_ok     = grant;

  // Allocation: all-or-nothing grant, tags compacted in slot order from head.
  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    reqs      = '0;
    grant_cnt = '0;
    for (int i = 0; i < ISSUE_W; i++) reqs = reqs + ptr_t'(fl.alloc_req[i]);
    grant = (reqs <= free_cnt) && !fl.flush_en;
    for (int i = 0; i < ISSUE_W; i++) begin
      fl.alloc_tag[i] = '0;
      if (grant && fl.alloc_req[i]) begin
        fl.alloc_tag[i] = fl_mem[IDX_W'(head + grant_cnt)];
        grant_cnt       = grant_cnt + ONE;
      end
    end
  end

  // Commit: free the superseded tag per slot, forwarding an earlier slot's
  // phys_rd when both slots retire the same architectural register.
  always_comb begin
    rel_cnt      = '0;
    cmt_cnt      = '0;
    wr_ptr       = '0;
    old_tag      = '0;
    fill         = '0;
    overflow_nxt = overflow_q;
    for (int i = 0; i < ISSUE_W; i++) begin
      rel_we[i]  = 1'b0;
      rmt_we[i]  = 1'b0;
      rel_idx[i] = '0;
      rel_tag[i] = '0;
      if (fl.commit_valid[i] && !fl.flush_en) begin
        old_tag = rmt[fl.commit_arch_rd[i]];
        for (int j = 0; j < ISSUE_W; j++) begin
          if (j < i && fl.commit_valid[j] &&
              fl.commit_arch_rd[j] == fl.commit_arch_rd[i])
            old_tag = fl.commit_phys_rd[j];
        end
        rmt_we[i] = 1'b1;
        cmt_cnt   = cmt_cnt + ONE;
        // A release that would push the list past FL_DEPTH is dropped.
        fill = {1'b0, free_cnt} + {1'b0, rel_cnt} + (CNT_W + 1)'(1);
        if (fill > DEPTH_X) begin
          overflow_nxt = 1'b1;
        end else begin
          wr_ptr     = tail + rel_cnt;
          rel_we[i]  = 1'b1;
          rel_idx[i] = IDX_W'(wr_ptr);
          rel_tag[i] = old_tag;
          rel_cnt    = rel_cnt + ONE;
        end
      end
    end
  end

  // Pointer next state: flush rewinds head and overrides alloc and commit.
  always_comb begin
    head_nxt        = head;
    commit_head_nxt = commit_head;
    tail_nxt        = tail;
    if (fl.flush_en) begin
      head_nxt = commit_head;
    end else begin
      if (grant) head_nxt = head + reqs;
      tail_nxt        = tail + rel_cnt;
      commit_head_nxt = commit_head + cmt_cnt;
    end
  end

  // Pointer and sticky-error registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= ptr_t'(FL_DEPTH);
      overflow_q  <= 1'b0;
    end else begin
      head        <= head_nxt;
      commit_head <= commit_head_nxt;
      tail        <= tail_nxt;
      overflow_q  <= overflow_nxt;
    end
  end

  // Free-list storage: released tags written at tail.
  // NOTE: this array is reset because its initial contents (ARCH_REGS+i)
  // are the free tags themselves, not don't-care data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) fl_mem[i] <= preg_tag_t'(ARCH_REGS + i);
    end else begin
      for (int i = 0; i < ISSUE_W; i++)
        if (rel_we[i]) fl_mem[rel_idx[i]] <= rel_tag[i];
    end
  end

  // Retirement map: later slot wins on a same-register double commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < ARCH_REGS; a++) rmt[a] <= preg_tag_t'(a);
    end else begin
      for (int i = 0; i < ISSUE_W; i++)
        if (rmt_we[i]) rmt[fl.commit_arch_rd[i]] <= fl.commit_phys_rd[i];
    end
  end

`ifdef FREELIST_STATS_EN
  ptr_t min_free_q;
  ptr_t next_free;

  assign next_free   = tail_nxt - head_nxt;
  assign fl.min_free = min_free_q;

  // Low-water mark of free_count; flush does not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     min_free_q <= ptr_t'(FL_DEPTH);
    else if (next_free < min_free_q) min_free_q <= next_free;
  end
`endif

endmodule

// File: tb/tb_preg_freelist.sv
// Scoreboard bench for preg_freelist: the driver pushes one expected record
// per cycle, the negedge monitor pops it and compares against the DUT.
module tb_preg_freelist;
  localparam int FL_DEPTH = 32;

  typedef logic [5:0] tag_t;
  typedef struct {
    string nm;
    logic  ok;
    tag_t  t0;
    tag_t  t1;
    tag_t  fc;
    logic  ovf;
    tag_t  mf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  exp_t sb [$];
  tag_t fq [$];
  tag_t hist [$];
  tag_t m_rmt [32];
  logic m_ovf;
  tag_t m_min;

  always #5 clk = ~clk;

  preg_freelist_if #(.NUM_PREGS(64), .ARCH_REGS(32), .ISSUE_W(2)) fl_if ();

  preg_freelist #(.NUM_PREGS(64), .ARCH_REGS(32), .ISSUE_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl_if.slave)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.nm, ".alloc_ok"},     32'(fl_if.alloc_ok),     32'(e.ok));
      check({e.nm, ".tag0"},         32'(fl_if.alloc_tag[0]), 32'(e.t0));
      check({e.nm, ".tag1"},         32'(fl_if.alloc_tag[1]), 32'(e.t1));
      check({e.nm, ".free_count"},   32'(fl_if.free_count),   32'(e.fc));
      check({e.nm, ".free_empty"},   32'(fl_if.free_empty),   32'(e.fc == 6'd0));
      check({e.nm, ".overflow_err"}, 32'(fl_if.overflow_err), 32'(e.ovf));
`ifdef FREELIST_STATS_EN
      check({e.nm, ".min_free"},     32'(fl_if.min_free),     32'(e.mf));
`endif
    end
  end

  task automatic drive(input logic [1:0] req, input logic [1:0] cv,
                       input logic [4:0] a0, input tag_t p0,
                       input logic [4:0] a1, input tag_t p1, input logic fls);
    fl_if.alloc_req         = req;
    fl_if.commit_valid      = cv;
    fl_if.commit_arch_rd[0] = a0;
    fl_if.commit_phys_rd[0] = p0;
    fl_if.commit_arch_rd[1] = a1;
    fl_if.commit_phys_rd[1] = p1;
    fl_if.flush_en          = fls;
  endtask

  task automatic model_reset();
    fq.delete();
    hist.delete();
    for (int i = 0; i < FL_DEPTH; i++) fq.push_back(6'(32 + i));
    for (int a = 0; a < 32; a++) m_rmt[a] = 6'(a);
    m_ovf = 1'b0;
    m_min = 6'd32;
  endtask

  // Behavioural reference: free tags and outstanding allocations as queues.
  task automatic model_step(input logic [1:0] req, input logic [1:0] cv,
                            input logic [4:0] a0, input tag_t p0,
                            input logic [4:0] a1, input tag_t p1, input logic fls,
                            output logic ok, output tag_t t0, output tag_t t1);
    int pre, rel, n;
    logic [4:0] a;
    tag_t p, old, dummy;
    n   = int'(req[0]) + int'(req[1]);
    pre = fq.size();
    ok  = (n <= pre) && !fls;
    t0  = '0;
    t1  = '0;
    if (fls) begin
      for (int k = hist.size() - 1; k >= 0; k--) fq.push_front(hist[k]);
      hist.delete();
    end else begin
      if (ok && req[0]) begin t0 = fq.pop_front(); hist.push_back(t0); end
      if (ok && req[1]) begin t1 = fq.pop_front(); hist.push_back(t1); end
      rel = 0;
      for (int s = 0; s < 2; s++) begin
        if (cv[s]) begin
          a = (s == 0) ? a0 : a1;
          p = (s == 0) ? p0 : p1;
          old = m_rmt[a];
          m_rmt[a] = p;
          if (hist.size() > 0) dummy = hist.pop_front();
          if (pre + rel + 1 > FL_DEPTH) m_ovf = 1'b1;
          else begin fq.push_back(old); rel++; end
        end
      end
    end
    if (fq.size() < int'(m_min)) m_min = 6'(fq.size());
  endtask

  // One cycle: drive, compute expectation (hand values override the model).
  task automatic step(input string nm, input logic [1:0] req, input logic [1:0] cv,
                      input logic [4:0] a0, input tag_t p0,
                      input logic [4:0] a1, input tag_t p1, input logic fls,
                      input bit hand, input logic h_ok,
                      input tag_t h_t0, input tag_t h_t1, input tag_t h_fc);
    exp_t e;
    logic ok;
    tag_t t0, t1;
    @(posedge clk); #1;
    drive(req, cv, a0, p0, a1, p1, fls);
    e.nm  = nm;
    e.fc  = 6'(fq.size());
    e.ovf = m_ovf;
    e.mf  = m_min;
    model_step(req, cv, a0, p0, a1, p1, fls, ok, t0, t1);
    e.ok = ok;
    e.t0 = t0;
    e.t1 = t1;
    if (hand) begin
      e.ok = h_ok;
      e.t0 = h_t0;
      e.t1 = h_t1;
      e.fc = h_fc;
    end
    sb.push_back(e);
  endtask

  task automatic alloc_h(input string nm, input logic [1:0] req, input logic ok,
                         input tag_t t0, input tag_t t1, input tag_t fc);
    step(nm, req, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 1'b1, ok, t0, t1, fc);
  endtask

  task automatic commit_h(input string nm, input logic [1:0] cv,
                          input logic [4:0] a0, input tag_t p0,
                          input logic [4:0] a1, input tag_t p1, input tag_t fc);
    step(nm, 2'b00, cv, a0, p0, a1, p1, 1'b0, 1'b1, 1'b1, 6'd0, 6'd0, fc);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [1:0] cv;
    logic [4:0] a0, a1;
    tag_t p0, p1;

    drive(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state, first allocation, registered count.
    alloc_h("idle_after_rst", 2'b00, 1'b1, 6'd0,  6'd0,  6'd32);
    alloc_h("alloc_32_33",    2'b11, 1'b1, 6'd32, 6'd33, 6'd32);
    alloc_h("count_30",       2'b00, 1'b1, 6'd0,  6'd0,  6'd30);

    // Drain to one free tag (63 remains).
    for (int i = 0; i < 14; i++)
      step("drain", 2'b11, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    step("drain", 2'b01, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);

    alloc_h("all_or_nothing", 2'b11, 1'b0, 6'd0, 6'd0,  6'd1);
    alloc_h("slot1_only",     2'b10, 1'b1, 6'd0, 6'd63, 6'd1);
    alloc_h("empty_deny",     2'b01, 1'b0, 6'd0, 6'd0,  6'd0);

    // Same-register double commit: frees 5 then 40, RMT[5] ends at 41.
    commit_h("commit_fwd", 2'b11, 5'd5, 6'd40, 5'd5, 6'd41, 6'd0);
    alloc_h("freed_5_40",  2'b11, 1'b1, 6'd5, 6'd40, 6'd2);
    commit_h("commit_rd5", 2'b01, 5'd5, 6'd42, 5'd0, 6'd0, 6'd0);
    alloc_h("rmt5_was_41", 2'b01, 1'b1, 6'd41, 6'd0, 6'd1);
    alloc_h("count_0",     2'b00, 1'b1, 6'd0,  6'd0, 6'd0);

    // Flush rollback: commit inputs in the flush cycle are ignored.
    do_reset();
    alloc_h("fl_alloc_a", 2'b11, 1'b1, 6'd32, 6'd33, 6'd32);
    alloc_h("fl_alloc_b", 2'b11, 1'b1, 6'd34, 6'd35, 6'd30);
    commit_h("fl_commit", 2'b01, 5'd1, 6'd32, 5'd0, 6'd0, 6'd28);
    step("flush", 2'b11, 2'b01, 5'd2, 6'd33, 5'd0, 6'd0, 1'b1,
         1'b1, 1'b0, 6'd0, 6'd0, 6'd29);
    alloc_h("after_flush", 2'b01, 1'b1, 6'd33, 6'd0, 6'd32);
    alloc_h("fc_31",       2'b00, 1'b1, 6'd0,  6'd0, 6'd31);

    // 40 cycles of 2-wide traffic across pointer wrap, with some forwarding.
    for (int i = 0; i < 40; i++) begin
      cv = 2'b00; p0 = '0; p1 = '0;
      if (hist.size() >= 2) begin cv = 2'b11; p0 = hist[0]; p1 = hist[1]; end
      else if (hist.size() == 1) begin cv = 2'b01; p0 = hist[0]; end
      a0 = 5'((i * 7) % 32);
      a1 = (i % 4 == 0) ? a0 : 5'((i * 7 + 3) % 32);
      step("traffic", 2'b11, cv, a0, p0, a1, p1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    end

    // Reset asserted mid-cycle during alloc+commit.
    @(posedge clk); #1;
    drive(2'b11, 2'b11, 5'd3, hist[0], 5'd4, hist[1], 1'b0);
    #2 reset = 1'b0;
    model_reset();
    e = '{nm: "midstream_reset", ok: 1'b1, t0: 6'd32, t1: 6'd33,
          fc: 6'd32, ovf: 1'b0, mf: 6'd32};
    sb.push_back(e);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0);
    reset = 1'b1;
    alloc_h("post_rst", 2'b11, 1'b1, 6'd32, 6'd33, 6'd32);

    // Release into a full list: write dropped, error sticky.
    do_reset();
    commit_h("ovf_commit", 2'b01, 5'd3, 6'd50, 5'd0, 6'd0, 6'd32);
    alloc_h("ovf_sticky",  2'b01, 1'b1, 6'd32, 6'd0, 6'd32);

    @(posedge clk); #1;
    drive(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0);
    @(negedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
